// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: memory op encoding, op-class
// masks and the FSM state type.
package mem_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_t;

    localparam int LANE_W = 4;

    // Bit n set when op encoding n belongs to the class.
    localparam logic [15:0] IS_LOAD  = 16'h003E;
    localparam logic [15:0] IS_STORE = 16'h01C0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte-enable merge, load extraction with
// sign/zero extension, and alignment check for the current op.
module lsu_align
    import mem_pkg::*;
(
    input  mem_op_t             op,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    input  logic [31:0]         old_word,
    output logic [LANE_W-1:0]   mask,
    output logic [31:0]         merged,
    output logic [31:0]         load_val,
    output logic                misalign
);

    logic [31:0] lane_data_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = old_word[{addr, 3'b000} +: 8];
    assign half_s = addr[1] ? old_word[31:16] : old_word[15:0];

    // Store data is replicated across lanes so the mask alone selects the target bytes.
    always_comb begin
        mask        = 4'b0000;
        lane_data_s = wdata;
        misalign    = 1'b0;
        case (op)
            SB: begin
                mask        = 4'b0001 << addr;
                lane_data_s = {4{wdata[7:0]}};
            end
            SH: begin
                mask        = addr[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata[15:0]}};
                misalign    = addr[0];
            end
            SW: begin
                mask     = 4'b1111;
                misalign = (addr != 2'b00);
            end
            LH, LHU: misalign = addr[0];
            LW:      misalign = (addr != 2'b00);
            default: mask = 4'b0000;
        endcase
    end

    // Byte merge keeps every unselected lane of the old word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANE_W; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = lane_data_s[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

    // Load extraction and extension.
    always_comb begin
        load_val = 32'd0;
        case (op)
            LB:      load_val = {{24{byte_s[7]}}, byte_s};
            LBU:     load_val = {24'd0, byte_s};
            LH:      load_val = {{16{half_s[15]}}, half_s};
            LHU:     load_val = {16'd0, half_s};
            LW:      load_val = old_word;
            default: load_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with word-addressed data memory, byte/half/word access, W->M store
// forwarding, address-error flags and an optional fixed access latency.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 0,
    parameter int TRACE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  mem_op_t     in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        fwd_sel,
    input  logic [31:0] fwd_data,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_alu,
    output logic [31:0] out_rdata,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    lsu_state_t        state_r, state_nx_s;
    logic [3:0]        cnt_r;
    mem_op_t           req_op_r;
    logic [31:0]       req_pc_r, req_addr_r, req_data_r;
    logic [31:0]       mem_r [DEPTH];

    mem_op_t           act_op_s;
    logic [31:0]       act_pc_s, act_addr_s, act_data_s;
    logic [AW-1:0]     idx_s;
    logic              oor_s, misalign_s, is_ld_s, is_st_s, err_s, slow_s;
    logic              exec_s, start_wait_s;
    logic [LANE_W-1:0] lane_mask_s;
    logic [31:0]       old_word_s, merged_s, load_val_s;
    logic              busy_r, out_valid_r, exc_adel_r, exc_ades_r;
    logic [31:0]       out_pc_r, out_alu_r, out_rdata_r;

    // The executing request is the latched one while waiting, else the live inputs.
    always_comb begin
        if (state_r == ST_WAIT) begin
            act_op_s   = req_op_r;
            act_pc_s   = req_pc_r;
            act_addr_s = req_addr_r;
            act_data_s = req_data_r;
        end else begin
            act_op_s   = in_op;
            act_pc_s   = in_pc;
            act_addr_s = in_addr;
            act_data_s = fwd_sel ? fwd_data : in_wdata;
        end
    end

    assign idx_s      = act_addr_s[AW+1:2];
    assign oor_s      = ((act_addr_s >> (AW + 2)) != 32'd0);
    assign is_ld_s    = IS_LOAD[act_op_s];
    assign is_st_s    = IS_STORE[act_op_s];
    assign err_s      = (is_ld_s | is_st_s) & (oor_s | misalign_s);
    assign slow_s     = (LATENCY != 0) && (is_ld_s || is_st_s) && !err_s;
    assign old_word_s = mem_r[idx_s];

    lsu_align u_align (
        .op       (act_op_s),
        .addr     (act_addr_s[1:0]),
        .wdata    (act_data_s),
        .old_word (old_word_s),
        .mask     (lane_mask_s),
        .merged   (merged_s),
        .load_val (load_val_s),
        .misalign (misalign_s)
    );

    // Next-state logic: error and NONE ops always complete on the accepting edge.
    always_comb begin
        state_nx_s   = state_r;
        exec_s       = 1'b0;
        start_wait_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (slow_s) begin
                        state_nx_s   = ST_WAIT;
                        start_wait_s = 1'b1;
                    end else begin
                        exec_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    exec_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register; busy is registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_WAIT);
        end
    end

    // Wait counter and latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r      <= 4'd0;
            req_op_r   <= NONE;
            req_pc_r   <= 32'd0;
            req_addr_r <= 32'd0;
            req_data_r <= 32'd0;
        end else if (start_wait_s) begin
            cnt_r      <= LAT_M1;
            req_op_r   <= act_op_s;
            req_pc_r   <= act_pc_s;
            req_addr_r <= act_addr_s;
            req_data_r <= act_data_s;
        end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Data memory: cleared on reset, written on the completing edge of a good store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (exec_s && is_st_s && !err_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // M/W output registers; everything but out_valid holds between completions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'd0;
            out_alu_r   <= 32'd0;
            out_rdata_r <= 32'd0;
            exc_adel_r  <= 1'b0;
            exc_ades_r  <= 1'b0;
        end else if (exec_s) begin
            out_valid_r <= 1'b1;
            out_pc_r    <= act_pc_s;
            out_alu_r   <= act_addr_s;
            out_rdata_r <= (is_ld_s && !err_s) ? load_val_s : 32'd0;
            exc_adel_r  <= is_ld_s && err_s;
            exc_ades_r  <= is_st_s && err_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_alu   = out_alu_r;
    assign out_rdata = out_rdata_r;
    assign exc_adel  = exc_adel_r;
    assign exc_ades  = exc_ades_r;

`ifndef SYNTHESIS
    generate
        if (TRACE != 0) begin : g_trace
            // Commit log of every store that actually writes memory.
            always_ff @(posedge clk) begin
                if (reset && exec_s && is_st_s && !err_s) begin
                    $display("@%08h: *%08h <= %08h", act_pc_s, {act_addr_s[31:2], 2'b00}, merged_s);
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a zero-latency and a three-cycle instance checked
// every cycle against a byte-level reference model, plus directed vectors.
module tb_mem_stage_lsu;
    import mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int NB    = DEPTH * 4;

    localparam logic [3:0] O_NONE = 4'd0, O_LB = 4'd1, O_LBU = 4'd2, O_LH = 4'd3,
                           O_LHU = 4'd4, O_LW = 4'd5, O_SB = 4'd6, O_SH = 4'd7, O_SW = 4'd8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fs;
        logic [31:0] fd;
        logic [31:0] rd;
        logic        adel;
        logic        ades;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  iv;
    logic [31:0] pc, addr, wdata, fdata;
    logic [3:0]  op;
    logic        fsel;

    logic [1:0]        busy, ov, adel, ades;
    logic [1:0][31:0]  opc, oalu, ord;

    logic [7:0]        mb [2][NB];
    int                wleft [2];
    req_t              pend [2];
    logic [1:0]        e_valid, e_adel, e_ades;
    logic [1:0][31:0]  e_pc, e_alu, e_rd;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tv [18];

    always #5 clk = ~clk;

    mem_stage_lsu #(.DEPTH(DEPTH), .LATENCY(0), .TRACE(1)) u_lat0 (
        .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_pc(pc), .in_op(mem_op_t'(op)),
        .in_addr(addr), .in_wdata(wdata), .fwd_sel(fsel), .fwd_data(fdata),
        .busy(busy[0]), .out_valid(ov[0]), .out_pc(opc[0]), .out_alu(oalu[0]),
        .out_rdata(ord[0]), .exc_adel(adel[0]), .exc_ades(ades[0])
    );

    mem_stage_lsu #(.DEPTH(DEPTH), .LATENCY(3), .TRACE(1)) u_lat3 (
        .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_pc(pc), .in_op(mem_op_t'(op)),
        .in_addr(addr), .in_wdata(wdata), .fwd_sel(fsel), .fwd_data(fdata),
        .busy(busy[1]), .out_valid(ov[1]), .out_pc(opc[1]), .out_alu(oalu[1]),
        .out_rdata(ord[1]), .exc_adel(adel[1]), .exc_ades(ades[1])
    );

    task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int op_size(input logic [3:0] o);
        if (o == O_LB || o == O_LBU || o == O_SB) return 1;
        else if (o == O_LH || o == O_LHU || o == O_SH) return 2;
        else return 4;
    endfunction

    function automatic bit is_ld(input logic [3:0] o);
        return (o >= O_LB && o <= O_LW);
    endfunction

    function automatic bit is_st(input logic [3:0] o);
        return (o >= O_SB && o <= O_SW);
    endfunction

    function automatic bit req_bad(input req_t r);
        int sz = op_size(r.op);
        return (is_ld(r.op) || is_st(r.op)) &&
               ((r.addr >= 32'(NB)) || ((r.addr % 32'(sz)) != 32'd0));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NB; i++) mb[d][i] = 8'd0;
            wleft[d] = 0;
        end
        e_valid = 2'b00; e_adel = 2'b00; e_ades = 2'b00;
        e_pc = '0; e_alu = '0; e_rd = '0;
    endtask

    task automatic complete(input int d, input req_t r);
        int sz = op_size(r.op);
        bit bad = req_bad(r);
        logic [31:0] v = 32'd0;
        int base;
        e_valid[d] = 1'b1;
        e_pc[d]    = r.pc;
        e_alu[d]   = r.addr;
        e_rd[d]    = 32'd0;
        e_adel[d]  = is_ld(r.op) && bad;
        e_ades[d]  = is_st(r.op) && bad;
        if (!bad && (is_ld(r.op) || is_st(r.op))) begin
            base = int'(r.addr[11:0]);
            for (int b = 0; b < sz; b++) begin
                if (is_st(r.op)) mb[d][base + b] = r.data[8*b +: 8];
                else v[8*b +: 8] = mb[d][base + b];
            end
            if (r.op == O_LB) v = {{24{v[7]}}, v[7:0]};
            if (r.op == O_LH) v = {{16{v[15]}}, v[15:0]};
            if (is_ld(r.op)) e_rd[d] = v;
        end
    endtask

    task automatic model_edge(input int d, input bit v);
        req_t r;
        int lat = (d == 0) ? 0 : 3;
        e_valid[d] = 1'b0;
        if (wleft[d] > 0) begin
            wleft[d]--;
            if (wleft[d] == 0) complete(d, pend[d]);
        end else if (v) begin
            r.op = op; r.pc = pc; r.addr = addr; r.data = fsel ? fdata : wdata;
            if (lat > 0 && (is_ld(r.op) || is_st(r.op)) && !req_bad(r)) begin
                pend[d]  = r;
                wleft[d] = lat;
            end else begin
                complete(d, r);
            end
        end
    endtask

    task automatic check_dut(input int d);
        chk(d == 0 ? "lat0_outputs" : "lat3_outputs",
            {ov[d], opc[d], oalu[d], ord[d], adel[d], ades[d], busy[d]},
            {e_valid[d], e_pc[d], e_alu[d], e_rd[d], e_adel[d], e_ades[d], wleft[d] > 0});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, iv[0]);
        model_edge(1, iv[1]);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic set_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                           input logic fs, input logic [31:0] fd, input logic [31:0] p);
        op = o; addr = a; wdata = w; fsel = fs; fdata = fd; pc = p;
    endtask

    initial begin
        logic [4:0] eb;
        logic [4:0] eo;
        tv[0]  = '{O_SW,   32'h10,   32'h8899AABB, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[1]  = '{O_LB,   32'h11,   32'h0,        1'b0, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b0};
        tv[2]  = '{O_LBU,  32'h11,   32'h0,        1'b0, 32'h0,        32'h000000AA, 1'b0, 1'b0};
        tv[3]  = '{O_LH,   32'h12,   32'h0,        1'b0, 32'h0,        32'hFFFF8899, 1'b0, 1'b0};
        tv[4]  = '{O_SB,   32'h13,   32'h00000011, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[5]  = '{O_LW,   32'h10,   32'h0,        1'b0, 32'h0,        32'h1199AABB, 1'b0, 1'b0};
        tv[6]  = '{O_LW,   32'h02,   32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
        tv[7]  = '{O_SW,   32'h04,   32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[8]  = '{O_SH,   32'h05,   32'h0000FFFF, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
        tv[9]  = '{O_LW,   32'h04,   32'h0,        1'b0, 32'h0,        32'h12345678, 1'b0, 1'b0};
        tv[10] = '{O_SW,   32'h20,   32'h0,        1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tv[11] = '{O_LW,   32'h20,   32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tv[12] = '{O_SW,   32'h1000, 32'h77777777, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
        tv[13] = '{O_LW,   32'h00,   32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[14] = '{O_LHU,  32'h12,   32'h0,        1'b0, 32'h0,        32'h00001199, 1'b0, 1'b0};
        tv[15] = '{O_LB,   32'h13,   32'h0,        1'b0, 32'h0,        32'h00000011, 1'b0, 1'b0};
        tv[16] = '{O_NONE, 32'h10,   32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tv[17] = '{O_LH,   32'h10,   32'h0,        1'b0, 32'h0,        32'hFFFFAABB, 1'b0, 1'b0};

        rst_n = 1'b0;
        iv = 2'b00;
        set_req(O_NONE, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_dut(0);
        check_dut(1);
        rst_n = 1'b1;

        // Directed vectors on the zero-latency instance, back to back.
        for (int i = 0; i < 18; i++) begin
            set_req(tv[i].op, tv[i].addr, tv[i].wdata, tv[i].fs, tv[i].fd, 32'h400 + 32'(4 * i));
            iv = 2'b01;
            tick();
            chk($sformatf("vec%0d", i), {96'd0, ov[0], ord[0], adel[0], ades[0], busy[0]},
                {96'd0, 1'b1, tv[i].rd, tv[i].adel, tv[i].ades, 1'b0});
        end
        iv = 2'b00;
        tick();
        chk("idle_hold", {67'd0, ov[0], ord[0]}, {67'd0, 1'b0, tv[17].rd});

        // Held store on the latency-3 instance: busy for three cycles, then re-accepted.
        set_req(O_SW, 32'h8, 32'hCAFEF00D, 1'b0, 32'd0, 32'h500);
        iv = 2'b10;
        eb = 5'b10111;
        eo = 5'b01000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("lat3_seq%0d", k), {98'd0, busy[1], ov[1]}, {98'd0, eb[k], eo[k]});
        end
        iv = 2'b00;
        repeat (4) tick();

        // Requests presented while busy are dropped without side effects.
        set_req(O_LW, 32'h8, 32'd0, 1'b0, 32'd0, 32'h504);
        iv = 2'b10;
        tick();
        set_req(O_SW, 32'h8, 32'hBAD0BAD0, 1'b0, 32'd0, 32'h508);
        repeat (2) tick();
        iv = 2'b00;
        tick();
        chk("busy_ignore", {67'd0, ov[1], ord[1]}, {67'd0, 1'b1, 32'hCAFEF00D});

        // Error and NONE ops bypass the latency.
        set_req(O_LW, 32'h2, 32'd0, 1'b0, 32'd0, 32'h50C);
        iv = 2'b10;
        tick();
        chk("err_nowait", {97'd0, ov[1], adel[1], busy[1]}, {97'd0, 3'b110});
        set_req(O_NONE, 32'h40, 32'd0, 1'b0, 32'd0, 32'h510);
        tick();
        chk("none_nowait", {98'd0, ov[1], busy[1]}, {98'd0, 2'b10});
        iv = 2'b00;
        tick();

        // Reset during WAIT drops the pending store.
        set_req(O_SW, 32'h30, 32'h00000055, 1'b0, 32'd0, 32'h514);
        iv = 2'b10;
        tick();
        iv = 2'b00;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        chk("rst_in_wait", {66'd0, busy[1], ov[1], opc[1]}, 100'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(O_LW, 32'h30, 32'd0, 1'b0, 32'd0, 32'h518);
        iv = 2'b10;
        tick();
        iv = 2'b00;
        repeat (3) tick();
        chk("rst_lost_store", {67'd0, ov[1], ord[1]}, {67'd0, 1'b1, 32'd0});

        // Randomized traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 63));
            set_req(4'($urandom_range(0, 8)), a, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
            iv = 2'($urandom_range(0, 3));
            tick();
        end
        iv = 2'b00;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline MEM stage.
- Holds a word-addressed data memory with byte/half/word loads and stores, sign/zero extension, and store-data forwarding from W.
- Flags misaligned and out-of-range accesses, and models a configurable memory latency with a busy/stall handshake toward the hazard unit.
- Sits between the E/M pipeline register and the W stage. All outputs are registered into the M/W boundary.

Parameters:
- DEPTH, 1024, number of 32-bit words in data memory (power of two, ≥4).
- LATENCY, 0, extra wait cycles per aligned, in-range load/store (0..15).
- TRACE, 1, when 1, each committed store prints "@<pc>: *<word_addr> <= <merged_word>" in simulation only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present from E/M register.
- in_pc  in  32  instruction PC.
- in_op  in  4  mem_op_t: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- in_addr  in  32  byte address (ALU result).
- in_wdata  in  32  rt value from E/M.
- fwd_sel  in  1  1 = use fwd_data as store data (W→M forward).
- fwd_data  in  32  W-stage write-back value.
- busy  out  1  stage cannot accept; upstream holds its inputs.
- out_valid  out  1  result valid toward W.
- out_pc  out  32  PC of the completed op.
- out_alu  out  32  in_addr passed through.
- out_rdata  out  32  extended load data; 0 for non-loads.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, every output 0, all memory words 0, any pending request discarded.
- Accept: request taken on a rising edge when in_valid=1 and busy=0. Store data = fwd_sel ? fwd_data : in_wdata, sampled at accept.
- Word index = in_addr[log2(DEPTH)+1:2].
- Out of range: any in_addr bit above log2(DEPTH)+1 set.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Byte ops are never misaligned.
- Error op (misaligned or out of range on a load/store):
  - no memory write; out_rdata=0; exc_adel for loads, exc_ades for stores;
  - completes with zero wait regardless of LATENCY.
- NONE op: never waits; out_rdata=0.
- FSM states: IDLE, WAIT.
- IDLE → WAIT when an aligned, in-range load/store is accepted and LATENCY>0. The counter loads LATENCY-1 and the request is latched.
- WAIT: busy=1. Counter decrements each cycle. When the counter is 0, the access executes on that edge and the FSM returns to IDLE.
- busy=1 exactly when state=WAIT, registered with no combinational path from inputs. The accepting cycle itself shows busy=0.
- Latency:
  - LATENCY=0: request accepted at edge N appears on outputs after edge N; out_valid=1 for one cycle per op; back-to-back every cycle.
  - LATENCY=k: result appears after edge N+k; busy=1 for cycles N+1..N+k.
- out_valid=0 in every cycle where no op completed; other outputs hold their last value.
- Store commit: the write occurs on the completing edge. Byte-enable merge:
  - SB writes lane addr[1:0] with wdata[7:0];
  - SH writes lanes {addr[1],0} with wdata[15:0];
  - SW writes the full word.
  - Unselected bytes are preserved.
  - TRACE prints the merged word.
- Load read: the word is read at the completing edge.
  - Extraction: LB/LBU pick the byte at addr[1:0]; LH/LHU pick the half at addr[1]; LW takes the word.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store immediately followed by a load to the same word: the load returns the merged post-store data. Memory is written before the next access is read.
- in_valid=1 while busy: ignored, with no side effects; upstream re-presents the request.
- Reset asserted during WAIT: the pending store is lost, memory is cleared, and nothing is printed.

Decomposition:
- Package mem_pkg holds:
  - mem_op_t enum, 4-bit encoding: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8;
  - helper constants IS_LOAD/IS_STORE;
  - lane-mask width 4.
- Sub-module lsu_align (combinational):
  - inputs op, addr[1:0], wdata, old word;
  - outputs 4-bit byte mask, merged store word, extended load value, misalign flag.
- The top holds the FSM, counter, memory array, output registers and trace.

Test Plan:
1. LATENCY=0, reset, SW addr 0x10 data 0x8899AABB, then LB 0x11 → out_rdata 0xFFFFFFAA; LBU 0x11 → 0x000000AA; LH 0x12 → 0xFFFF8899; busy stays 0.
2. SB 0x13 data 0x11 after test 1 contents, then LW 0x10 → 0x1199AABB. Trace shows "*00000010 <= 1199aabb".
3. LW addr 0x02 → exc_adel=1, out_rdata 0, out_valid one cycle later. SH addr 0x05 → exc_ades=1, memory word 1 unchanged.
4. LATENCY=3: LW accepted at edge N with in_valid held → busy=1 for N+1..N+3, out_valid only after N+3. The next request is accepted at the edge following busy falling.
5. SW with fwd_sel=1, fwd_data 0xDEADBEEF, in_wdata 0 → LW reads 0xDEADBEEF. Out-of-range address DEPTH*4 → exc_ades, no write.
6. LATENCY=2: SW issued, reset pulled low during WAIT → all outputs 0 immediately, no trace line, LW of that address returns 0.
